hazard_ctrl_mdu: RTL

Parametrised next-generation pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Performs Tuse/Tnew stall detection and D/E/M forwarding-select generation with configurable register-address and timing-field widths.
- Adds a sequential multiply/divide unit (MDU) busy tracker that stalls HI/LO-dependent instructions in D.
- Adds an optional stall-cycle performance counter.

---
 rtl/hazard_ctrl_mdu.sv | 112 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl_mdu.sv
// hazard_ctrl_mdu: Tuse/Tnew stall + forwarding control with MDU busy tracking.
// Optional stall-cycle counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl_mdu #(
   parameter int ADDR_W  = 5,
   parameter int T_W     = 3,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rf_we_e,
   input  logic              rf_we_m,
   input  logic              rf_we_w,
   input  logic [ADDR_W-1:0] dst_e,
   input  logic [ADDR_W-1:0] dst_m,
   input  logic [ADDR_W-1:0] dst_w,
   input  logic [T_W-1:0]    tnew_e,
   input  logic [T_W-1:0]    tnew_m,
   input  logic [T_W-1:0]    tnew_w,
   input  logic [ADDR_W-1:0] rs_d,
   input  logic [ADDR_W-1:0] rt_d,
   input  logic [ADDR_W-1:0] rs_e,
   input  logic [ADDR_W-1:0] rt_e,
   input  logic [T_W-1:0]    tuse_rs,
   input  logic [T_W-1:0]    tuse_rt,
   input  logic              dm_we_m,
   input  logic              clr_slot,
   input  logic              md_use_d,
   input  logic              md_start_e,
   input  logic              md_op_e,
   output logic              pc_en,
   output logic              en_d,
   output logic              flush_e,
   output logic              flush_d,
   output logic              fwd_rs_d,
   output logic              fwd_rt_d,
   output logic [1:0]        fwd_rs_e,
   output logic [1:0]        fwd_rt_e,
   output logic              fwd_m,
   output logic              md_busy,
   output logic [CNT_W-1:0]  stall_cnt
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [7:0] MUL_L = 8'(MUL_LAT - 1);
   localparam logic [7:0] DIV_L = 8'(DIV_LAT - 1);
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       data_stall, md_stall, stall;
   logic       e_rs, e_rt, m_rs, m_rt, w_rs, w_rt, m_rse, m_rte, w_rse, w_rte, w_dm;
   function automatic logic hit(input logic we, input logic [ADDR_W-1:0] dst, input logic [ADDR_W-1:0] r);
      return we && dst != '0 && dst == r;
   endfunction
   assign e_rs  = hit(rf_we_e, dst_e, rs_d);
   assign e_rt  = hit(rf_we_e, dst_e, rt_d);
   assign m_rs  = hit(rf_we_m, dst_m, rs_d);
   assign m_rt  = hit(rf_we_m, dst_m, rt_d);
   assign w_rs  = hit(rf_we_w, dst_w, rs_d);
   assign w_rt  = hit(rf_we_w, dst_w, rt_d);
   assign m_rse = hit(rf_we_m, dst_m, rs_e) && tnew_m == '0;
   assign m_rte = hit(rf_we_m, dst_m, rt_e) && tnew_m == '0;
   assign w_rse = hit(rf_we_w, dst_w, rs_e) && tnew_w == '0;
   assign w_rte = hit(rf_we_w, dst_w, rt_e) && tnew_w == '0;
   assign w_dm  = hit(rf_we_w, dst_w, dst_m);
   // busy is masked while reset is held so the combinational outputs see an idle MDU
   assign md_busy    = reset && state_q == BUSY;
   assign data_stall = (e_rs && tuse_rs < tnew_e) || (e_rt && tuse_rt < tnew_e) ||
                       (m_rs && tuse_rs < tnew_m) || (m_rt && tuse_rt < tnew_m) ||
                       (w_rs && tuse_rs < tnew_w) || (w_rt && tuse_rt < tnew_w);
   assign md_stall   = md_use_d && (md_busy || md_start_e);
   assign stall      = data_stall || md_stall;
   assign pc_en      = ~stall;
   assign en_d       = ~stall;
   assign flush_e    = stall;
   assign flush_d    = ~stall && clr_slot;
   assign fwd_rs_d   = m_rs && tnew_m == '0;
   assign fwd_rt_d   = m_rt && tnew_m == '0;
   assign fwd_rs_e   = m_rse ? 2'b01 : w_rse ? 2'b10 : 2'b00;
   assign fwd_rt_e   = m_rte ? 2'b01 : w_rte ? 2'b10 : 2'b00;
   assign fwd_m      = w_dm && dm_we_m && tnew_w == '0;
   // a new start always reloads, even over a finishing operation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (md_start_e) begin
         state_d = BUSY;
         cnt_d   = md_op_e ? DIV_L : MUL_L;
      end else if (state_q == BUSY) begin
         state_d = cnt_q == '0 ? IDLE : BUSY;
         cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 8'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] sc_q;
   always_ff @(posedge clk) begin
      if (!reset) sc_q <= '0;
      else if (stall && ~&sc_q) sc_q <= sc_q + 1'b1;
   end
   assign stall_cnt = sc_q;
`else
   assign stall_cnt = '0;
`endif
endmodule
